// File: rtl/node_memory_responder_pkg.sv
// rtl/node_memory_responder_pkg.sv - MA request/result field layout, node layout and FSM states
package node_memory_responder_pkg;

  typedef enum logic [1:0] {
    MA_TYPE_2_FETCH_NODE      = 2'd0,
    MA_TYPE_2_INSERT_NODE     = 2'd1,
    MA_TYPE_2_WRITE_NODE_NEXT = 2'd2,
    MA_TYPE_2_RESERVED        = 2'd3
  } ma_type_e;

  localparam int MA_REQUEST_DATA_LSB               = 0;
  localparam int MA_REQUEST_DATA_MSB               = 95;
  localparam int MA_REQUEST_BDDINDEX_NO_NEGATE_LSB = 96;
  localparam int MA_REQUEST_BDDINDEX_NO_NEGATE_MSB = 124;
  localparam int MA_REQUEST_TYPE_2_LSB             = 125;
  localparam int MA_REQUEST_TYPE_2_MSB             = 126;

  localparam int NODE_THEN_LSB = 0;
  localparam int NODE_THEN_MSB = 29;
  localparam int NODE_ELSE_LSB = 30;
  localparam int NODE_ELSE_MSB = 59;
  localparam int NODE_NEXT_LSB = 60;
  localparam int NODE_NEXT_MSB = 89;

  localparam int INDEX_BITS       = 30;
  localparam int VAR_BITS_DEFAULT = 10;

  typedef logic [INDEX_BITS-1:0]       index_t;
  typedef logic [VAR_BITS_DEFAULT-1:0] var_t;

  localparam index_t BDD_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_RESPOND = 2'd2
  } resp_state_e;

  // Bit 0 of an index is the negate flag; a freshly allocated node is never negated.
  function automatic index_t node_to_index(input logic [INDEX_BITS-2:0] addr);
    return {addr, 1'b0};
  endfunction

endpackage

// File: rtl/node_memory_responder_node_ram_sdp.sv
// rtl/node_memory_responder_node_ram_sdp.sv - simple dual-port RAM, one write port, one registered read port
module node_ram_sdp #(
  parameter int DATA_BITS = 30,
  parameter int ADDR_BITS = 14
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [DATA_BITS-1:0] i_wdata,
  input  logic                 i_re,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [DATA_BITS-1:0] o_rdata
);

  logic [DATA_BITS-1:0] r_mem [2**ADDR_BITS];
  logic [DATA_BITS-1:0] r_rdata;

  // No reset: contents and read register survive reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/node_memory_responder.sv
// rtl/node_memory_responder.sv - MA responder: fetch/insert/write-next served from node RAM with bump allocator
module node_memory_responder
  import node_memory_responder_pkg::*;
#(
  parameter int NODE_ADDR_BITS = 14,
  parameter int VAR_BITS       = VAR_BITS_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [127:0]              asi_request_data,
  input  logic [1:0]                asi_request_channel,
  input  logic                      asi_request_valid,
  output logic                      asi_request_ready,
  output logic [95:0]               aso_result_data,
  output logic [1:0]                aso_result_channel,
  output logic                      aso_result_valid,
  input  logic                      aso_result_ready,
  output logic [NODE_ADDR_BITS-1:0] node_count,
  output logic                      full
);

  localparam logic [NODE_ADDR_BITS-1:0] LAST_ADDR = '1;

  resp_state_e               r_state;
  resp_state_e               w_state_next;
  logic                      r_ready;
  logic [95:0]               r_result_data;
  logic [1:0]                r_result_channel;
  logic [NODE_ADDR_BITS-1:0] r_node_count;
  logic                      r_full;

  logic                      w_accept;
  ma_type_e                  w_type;
  logic [28:0]               w_index;
  logic [NODE_ADDR_BITS-1:0] w_addr;
  logic [95:0]               w_data;
  logic                      w_alloc_full;
  logic                      w_node_we;
  logic                      w_next_we;
  logic                      w_rd_en;
  logic [NODE_ADDR_BITS-1:0] w_next_waddr;
  logic [29:0]               w_next_wdata;
  logic [59:0]               w_te_rdata;
  logic [29:0]               w_next_rdata;
  logic [VAR_BITS-1:0]       w_var_rdata_unused;
  logic                      w_unused_bits;

  assign w_type       = ma_type_e'(asi_request_data[MA_REQUEST_TYPE_2_MSB:MA_REQUEST_TYPE_2_LSB]);
  assign w_index      = asi_request_data[MA_REQUEST_BDDINDEX_NO_NEGATE_MSB:MA_REQUEST_BDDINDEX_NO_NEGATE_LSB];
  assign w_data       = asi_request_data[MA_REQUEST_DATA_MSB:MA_REQUEST_DATA_LSB];
  assign w_addr       = w_index[NODE_ADDR_BITS-1:0];
  assign w_accept     = asi_request_valid & r_ready;
  // The top address is never handed out so the allocator pointer cannot wrap.
  assign w_alloc_full = (r_node_count == LAST_ADDR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_node_we    = 1'b0;
    w_next_we    = 1'b0;
    w_rd_en      = 1'b0;
    w_next_waddr = r_node_count;
    w_next_wdata = w_data[NODE_NEXT_MSB:NODE_NEXT_LSB];
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (w_type)
            MA_TYPE_2_FETCH_NODE: begin
              w_rd_en      = 1'b1;
              w_state_next = ST_READ;
            end
            MA_TYPE_2_INSERT_NODE: begin
              w_node_we    = !w_alloc_full;
              w_next_we    = !w_alloc_full;
              w_state_next = ST_RESPOND;
            end
            MA_TYPE_2_WRITE_NODE_NEXT: begin
              w_next_we    = 1'b1;
              w_next_waddr = w_addr;
              w_next_wdata = w_data[29:0];
            end
            default: ;
          endcase
        end
      end
      ST_READ:    w_state_next = ST_RESPOND;
      ST_RESPOND: if (aso_result_ready) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ready          <= 1'b0;
      r_result_data    <= '0;
      r_result_channel <= '0;
      r_node_count     <= NODE_ADDR_BITS'(1);
      r_full           <= 1'b0;
    end else begin
      r_ready <= (w_state_next == ST_IDLE);
      if (w_accept && (w_type == MA_TYPE_2_FETCH_NODE)) begin
        r_result_channel <= asi_request_channel;
      end
      if (w_accept && (w_type == MA_TYPE_2_INSERT_NODE)) begin
        r_result_channel <= asi_request_channel;
        if (w_alloc_full) begin
          r_full        <= 1'b1;
          r_result_data <= 96'(BDD_ZERO);
        end else begin
          r_result_data <= 96'(node_to_index(29'(r_node_count)));
          r_node_count  <= r_node_count + NODE_ADDR_BITS'(1);
        end
      end
      if (r_state == ST_READ) begin
        r_result_data <= {6'b0, w_next_rdata, w_te_rdata};
      end
    end
  end

  node_ram_sdp #(.DATA_BITS(60), .ADDR_BITS(NODE_ADDR_BITS)) u_then_else_ram (
    .clk     (clk),
    .i_we    (w_node_we),
    .i_waddr (r_node_count),
    .i_wdata (w_data[NODE_ELSE_MSB:NODE_THEN_LSB]),
    .i_re    (w_rd_en),
    .i_raddr (w_addr),
    .o_rdata (w_te_rdata)
  );

  node_ram_sdp #(.DATA_BITS(30), .ADDR_BITS(NODE_ADDR_BITS)) u_next_ram (
    .clk     (clk),
    .i_we    (w_next_we),
    .i_waddr (w_next_waddr),
    .i_wdata (w_next_wdata),
    .i_re    (w_rd_en),
    .i_raddr (w_addr),
    .o_rdata (w_next_rdata)
  );

  // Variable field is stored for later consumers; nothing here reads it back.
  node_ram_sdp #(.DATA_BITS(VAR_BITS), .ADDR_BITS(NODE_ADDR_BITS)) u_var_ram (
    .clk     (clk),
    .i_we    (w_node_we),
    .i_waddr (r_node_count),
    .i_wdata (w_index[VAR_BITS-1:0]),
    .i_re    (1'b0),
    .i_raddr ('0),
    .o_rdata (w_var_rdata_unused)
  );

  assign w_unused_bits = ^{asi_request_data[127], asi_request_data[95:90], w_index};

  assign asi_request_ready  = r_ready;
  assign aso_result_valid   = (r_state == ST_RESPOND);
  assign aso_result_data    = r_result_data;
  assign aso_result_channel = r_result_channel;
  assign node_count         = r_node_count;
  assign full               = r_full;

endmodule

// File: tb/tb_node_memory_responder.sv
// tb/tb_node_memory_responder.sv - self-checking bench: node-table model plus directed literal checks
module tb_node_memory_responder;

  localparam int AB = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [127:0]  req_data;
  logic [1:0]    req_ch;
  logic          req_valid;
  logic          req_ready;
  logic [95:0]   res_data;
  logic [1:0]    res_ch;
  logic          res_valid;
  logic          res_ready;
  logic [AB-1:0] ncount;
  logic          full;

  logic [127:0]  s_req_data;
  logic [1:0]    s_req_ch;
  logic          s_req_valid;
  logic          s_req_ready;
  logic [95:0]   s_res_data;
  logic [1:0]    s_res_ch;
  logic          s_res_valid;
  logic          s_res_ready;
  logic [1:0]    s_ncount;
  logic          s_full;

  node_memory_responder #(.NODE_ADDR_BITS(AB)) dut (
    .clk(clk), .reset(rst_n),
    .asi_request_data(req_data), .asi_request_channel(req_ch),
    .asi_request_valid(req_valid), .asi_request_ready(req_ready),
    .aso_result_data(res_data), .aso_result_channel(res_ch),
    .aso_result_valid(res_valid), .aso_result_ready(res_ready),
    .node_count(ncount), .full(full)
  );

  node_memory_responder #(.NODE_ADDR_BITS(2)) dut_small (
    .clk(clk), .reset(rst_n),
    .asi_request_data(s_req_data), .asi_request_channel(s_req_ch),
    .asi_request_valid(s_req_valid), .asi_request_ready(s_req_ready),
    .aso_result_data(s_res_data), .aso_result_channel(s_res_ch),
    .aso_result_valid(s_res_valid), .aso_result_ready(s_res_ready),
    .node_count(s_ncount), .full(s_full)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=no event required=event", name);
  endtask

  // Model: the node table as the requester sees it, plus results owed in order.
  typedef struct {
    logic [95:0] data;
    logic [1:0]  ch;
  } res_t;

  logic [29:0] m_then [int];
  logic [29:0] m_else [int];
  logic [29:0] m_next [int];
  int          m_count;
  bit          m_full;
  res_t        exp_q [$];
  bit          model_on;

  task automatic model_accept(input logic [1:0] typ, input logic [28:0] idx,
                              input logic [95:0] data, input logic [1:0] ch);
    int   a;
    res_t r;
    a    = int'(idx[AB-1:0]);
    r.ch = ch;
    case (typ)
      2'd0: begin
        r.data = '0;
        if (m_then.exists(a)) r.data[59:0]  = {m_else[a], m_then[a]};
        if (m_next.exists(a)) r.data[89:60] = m_next[a];
        exp_q.push_back(r);
      end
      2'd1: begin
        if (m_count == (1 << AB) - 1) begin
          m_full = 1'b1;
          r.data = '0;
        end else begin
          m_then[m_count] = data[29:0];
          m_else[m_count] = data[59:30];
          m_next[m_count] = data[89:60];
          r.data  = 96'(2 * m_count);
          m_count = m_count + 1;
        end
        exp_q.push_back(r);
      end
      2'd2: m_next[a] = data[29:0];
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (model_on && rst_n) begin
      chk("node_count", 128'(ncount), 128'(m_count));
      chk("full", 128'(full), 128'(m_full));
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          chk("result_data", 128'(res_data), 128'(exp_q[0].data));
          chk("result_channel", 128'(res_ch), 128'(exp_q[0].ch));
          if (res_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [1:0] typ, input logic [28:0] idx,
                      input logic [95:0] data, input logic [1:0] ch);
    int w = 0;
    @(negedge clk);
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      fail_now("request_ready_timeout");
      return;
    end
    req_data  = {1'b0, typ, idx, data};
    req_ch    = ch;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    model_accept(typ, idx, data, ch);
  endtask

  task automatic wait_idle();
    int w = 0;
    @(negedge clk);
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) fail_now("idle_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  int exp_sd [4] = '{2, 4, 0, 0};
  int exp_sc [4] = '{2, 3, 3, 3};
  int exp_sf [4] = '{0, 0, 1, 1};

  initial begin
    rst_n = 1'b0;
    req_data = '0; req_ch = '0; req_valid = 1'b0; res_ready = 1'b1;
    s_req_data = '0; s_req_ch = '0; s_req_valid = 1'b0; s_res_ready = 1'b1;
    m_count = 1; m_full = 1'b0; model_on = 1'b0;

    #12;
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_valid", 128'(res_valid), 128'(0));
    chk("rst_data", 128'(res_data), 128'(0));
    chk("rst_channel", 128'(res_ch), 128'(0));
    chk("rst_node_count", 128'(ncount), 128'(1));
    chk("rst_full", 128'(full), 128'(0));
    chk("rst_small_node_count", 128'(s_ncount), 128'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_on = 1'b1;

    // Insert then=0x10 else=0x20 next=0 top=5 on channel 1: valid at N+1.
    send(2'd1, 29'd5, {6'd0, 30'd0, 30'h20, 30'h10}, 2'd1);
    @(negedge clk);
    chk("ins_valid_n1", 128'(res_valid), 128'(1));
    chk("ins_data", 128'(res_data), 128'h2);
    chk("ins_channel", 128'(res_ch), 128'(1));
    chk("ins_node_count", 128'(ncount), 128'(2));

    // Fetch address 1 on channel 2: nothing at N+1, node at N+2.
    send(2'd0, 29'd1, 96'd0, 2'd2);
    @(negedge clk);
    chk("fetch_valid_n1", 128'(res_valid), 128'(0));
    @(negedge clk);
    chk("fetch_valid_n2", 128'(res_valid), 128'(1));
    chk("fetch_data", 128'(res_data), 128'h8_0000_0010);
    chk("fetch_channel", 128'(res_ch), 128'(2));

    // Write-next then an immediate fetch of the same node.
    send(2'd2, 29'd1, 96'h6, 2'd0);
    send(2'd0, 29'd1, 96'd0, 2'd3);
    @(negedge clk);
    chk("raw_valid_n1", 128'(res_valid), 128'(0));
    @(negedge clk);
    chk("raw_data", 128'(res_data), 128'h6000_0008_0000_0010);
    chk("raw_channel", 128'(res_ch), 128'(3));

    // Backpressure: result held for 5 cycles, handshake on the 6th.
    wait_idle();
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    send(2'd0, 29'd1, 96'd0, 2'd1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 128'(res_valid), 128'(1));
      chk("hold_data", 128'(res_data), 128'h6000_0008_0000_0010);
      chk("hold_channel", 128'(res_ch), 128'(1));
      chk("hold_req_ready", 128'(req_ready), 128'(0));
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("hold_valid_c6", 128'(res_valid), 128'(1));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("hold_valid_after", 128'(res_valid), 128'(0));
    chk("hold_ready_after", 128'(req_ready), 128'(1));

    // Reserved type is dropped.
    send(2'd3, 29'd1, 96'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rsv_req_ready", 128'(req_ready), 128'(1));
      chk("rsv_valid", 128'(res_valid), 128'(0));
    end

    // Second node, then read it back.
    send(2'd1, 29'd7, {6'd0, 30'h3, 30'h222, 30'h111}, 2'd3);
    @(negedge clk);
    chk("ins2_data", 128'(res_data), 128'h4);
    send(2'd0, 29'd2, 96'd0, 2'd0);
    @(negedge clk);
    @(negedge clk);
    chk("fetch2_data", 128'(res_data), 128'h3000_0088_8000_0111);

    // Small allocator: address 3 is never handed out, full is sticky.
    for (int i = 0; i < 4; i++) begin
      int w = 0;
      @(negedge clk);
      while (!s_req_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (!s_req_ready) fail_now("small_ready_timeout");
      s_req_data  = {1'b0, 2'd1, 29'(i + 3), 6'd0, 30'd0, 30'(i), 30'(i + 1)};
      s_req_ch    = 2'(i);
      s_req_valid = 1'b1;
      @(posedge clk);
      #1;
      s_req_valid = 1'b0;
      @(negedge clk);
      chk("small_valid", 128'(s_res_valid), 128'(1));
      chk("small_data", 128'(s_res_data), 128'(exp_sd[i]));
      chk("small_channel", 128'(s_res_ch), 128'(i));
      chk("small_node_count", 128'(s_ncount), 128'(exp_sc[i]));
      chk("small_full", 128'(s_full), 128'(exp_sf[i]));
    end

    // Reset while a result is pending.
    wait_idle();
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    send(2'd1, 29'd9, {6'd0, 30'h1, 30'h2, 30'h3}, 2'd2);
    @(negedge clk);
    chk("prerst_valid", 128'(res_valid), 128'(1));
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    m_count = 1;
    m_full  = 1'b0;
    #1;
    chk("rst_async_valid", 128'(res_valid), 128'(0));
    chk("rst_async_data", 128'(res_data), 128'(0));
    chk("rst_async_req_ready", 128'(req_ready), 128'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("postrst_req_ready", 128'(req_ready), 128'(1));
    chk("postrst_node_count", 128'(ncount), 128'(1));
    chk("postrst_valid", 128'(res_valid), 128'(0));
    chk("postrst_small_full", 128'(s_full), 128'(0));

    // RAM is not cleared by reset.
    send(2'd0, 29'd1, 96'd0, 2'd1);
    @(negedge clk);
    @(negedge clk);
    chk("postrst_fetch_data", 128'(res_data), 128'h6000_0008_0000_0010);

    repeat (4) @(negedge clk);
    chk("results_drained", 128'(exp_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
